codificador_teclado_sync: RTL

Clocked, parametrised keypad encoder for the timer-entry path. Synchronises and debounces an N-key one-hot-ish key vector and resolves simultaneous presses by fixed priority (highest index wins). Emits exactly one encoded event per physical press through a valid/ready handshake to the digit-entry logic. Replaces the purely combinational encoder. Adds debounce, press/release tracking, an overflow flag and a full decode of every key, including key 0.

---
 rtl/codificador_teclado_sync_pkg.sv | 19 +
 rtl/codificador_teclado_sync_if.sv | 13 +
 rtl/codificador_teclado_sync_debounce_vetor.sv | 48 ++++
 rtl/codificador_teclado_sync.sv | 84 ++++++++
 4 files changed

// File: rtl/codificador_teclado_sync_pkg.sv
// Shared types, defaults and the priority-encode helper for the keypad encoder.
package codificador_pkg;

  typedef enum logic {IDLE = 1'b0, HELD = 1'b1} state_t;

  localparam int N_KEYS_DEF          = 10;
  localparam int CODE_W_DEF          = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int PRIO_MAX            = 32;

  // Highest set bit index; an all-zero vector encodes to 0.
  function automatic int unsigned prio_enc(input logic [PRIO_MAX-1:0] vec);
    prio_enc = 0;
    for (int unsigned i = 0; i < PRIO_MAX; i++) begin
      if (vec[i]) prio_enc = i;
    end
  endfunction

endpackage

// File: rtl/codificador_teclado_sync_if.sv
// Event handshake between the keypad encoder (master) and the digit-entry logic (slave).
// valid/ready: master raises valid with a stable code and holds both until the
// cycle where valid && ready; the transfer happens at that rising edge.
interface codificador_teclado_sync_if #(
  parameter int CODE_W = 4
);
  logic [CODE_W-1:0] code;
  logic              valid;
  logic              ready;

  modport master (output code, output valid, input ready);
  modport slave  (input code, input valid, output ready);
endinterface

// File: rtl/codificador_teclado_sync_debounce_vetor.sv
// Two-flop synchroniser followed by a whole-vector debouncer.
import codificador_pkg::*;

module debounce_vetor #(
  parameter int N_KEYS          = N_KEYS_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [N_KEYS-1:0] entrada,
  output logic [N_KEYS-1:0] deb_vec
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_KEYS-1:0] sync_q1;
  logic [N_KEYS-1:0] sync_vec;
  logic [N_KEYS-1:0] cand;
  logic [CNT_W-1:0]  cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync_q1  <= '0;
      sync_vec <= '0;
    end else begin
      sync_q1  <= entrada;
      sync_vec <= sync_q1;
    end
  end

  // Any change restarts the stability window; cnt saturates at its terminal value.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cand    <= '0;
      cnt     <= '0;
      deb_vec <= '0;
    end else if (sync_vec != cand) begin
      cand <= sync_vec;
      cnt  <= '0;
    end else if (cnt == CNT_MAX) begin
      deb_vec <= cand;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/codificador_teclado_sync.sv
// Keypad encoder: debounced vector, press/release FSM, one event per press,
// valid/ready event register and a sticky overflow flag for dropped events.
import codificador_pkg::*;

module codificador_teclado_sync #(
  parameter int N_KEYS          = N_KEYS_DEF,
  parameter int CODE_W          = CODE_W_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [N_KEYS-1:0]          entrada,
  input  logic                       enablen,
  codificador_teclado_sync_if.master bus,
  output logic                       overflow,
  input  logic                       ovf_clear,
  output state_t                     state_dbg
);

  logic [N_KEYS-1:0]   deb_vec;
  logic [PRIO_MAX-1:0] deb_ext;
  logic [CODE_W-1:0]   key_idx;
  state_t              state, state_n;
  logic                capture;
  logic                load_ev;
  logic                drop_ev;

  debounce_vetor #(
    .N_KEYS          (N_KEYS),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_deb (
    .clock   (clock),
    .resetn  (resetn),
    .entrada (entrada),
    .deb_vec (deb_vec)
  );

  assign deb_ext = PRIO_MAX'(deb_vec);
  assign key_idx = CODE_W'(prio_enc(deb_ext));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (deb_vec != '0) state_n = HELD;
      HELD:    if (deb_vec == '0) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The FSM keeps tracking while disabled, so a key held across enablen
  // falling is only reported after a full release and re-press.
  always_comb begin
    capture = (state == IDLE) && (deb_vec != '0);
    load_ev = capture && !enablen && (!bus.valid || bus.ready);
    drop_ev = capture && !enablen && bus.valid && !bus.ready;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bus.code  <= '0;
      bus.valid <= 1'b0;
    end else if (load_ev) begin
      bus.code  <= key_idx;
      bus.valid <= 1'b1;
    end else if (bus.valid && bus.ready) begin
      bus.valid <= 1'b0;
    end
  end

  // A drop in the same cycle as ovf_clear keeps the flag set.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)        overflow <= 1'b0;
    else if (drop_ev)   overflow <= 1'b1;
    else if (ovf_clear) overflow <= 1'b0;
  end

  assign state_dbg = state;

endmodule
